// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer.
// Holds default widths, the unit-select encoding of cmd_fun[3:2],
// the sequencer FSM state type and the one-hot unit enable bundle.
package alu_pkg;

    localparam int unsigned A_WIDTH_DEF   = 16;
    localparam int unsigned B_WIDTH_DEF   = 16;
    localparam int unsigned OUT_WIDTH_DEF = 16;
    localparam int unsigned FUN_W         = 4;
    localparam int unsigned UNIT_W        = 2;

    // Unit select carried in the upper two bits of the function code
    localparam logic [UNIT_W-1:0] UNIT_ARITH = 2'b00;
    localparam logic [UNIT_W-1:0] UNIT_LOGIC = 2'b01;
    localparam logic [UNIT_W-1:0] UNIT_CMP   = 2'b10;
    localparam logic [UNIT_W-1:0] UNIT_SHIFT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic shift_en;
        logic cmp_en;
        logic logic_en;
        logic arith_en;
    } unit_en_t;

endpackage

// File: rtl/alu_fun_decode.sv
// Combinational unit-enable decoder.
// Ports: unit_sel - 2-bit unit select; issue - strobe qualifying the decode;
//        en_c     - one-hot enable bundle, all zero when issue is low.
module alu_fun_decode
    import alu_pkg::*;
(
    input  logic [UNIT_W-1:0] unit_sel,
    input  logic              issue,
    output unit_en_t          en_c
);

    // At most one enable, and only while the strobe is up
    always_comb begin
        en_c = '0;
        if (issue) begin
            case (unit_sel)
                UNIT_ARITH: en_c.arith_en = 1'b1;
                UNIT_LOGIC: en_c.logic_en = 1'b1;
                UNIT_CMP:   en_c.cmp_en   = 1'b1;
                UNIT_SHIFT: en_c.shift_en = 1'b1;
                default:    en_c = '0;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// ALU command sequencer: accepts one command, broadcasts registered operands
// and function code to four ALU units, pulses the selected unit's enable for
// one cycle, captures that unit's registered result and flag, and holds the
// response until it is consumed.
// Ports:
//   clk, rst                     - clock, async active-low reset
//   cmd_valid/cmd_ready          - command handshake; cmd_fun, cmd_a, cmd_b payload
//   A, B, ALU_FUN                - registered operands / function to all units
//   *_Enable                     - one-hot unit enables (registered)
//   *_OUT, *_Flag                - unit results and flags
//   rsp_valid/rsp_ready          - response handshake; rsp_data, rsp_unit, rsp_flag payload
// Build option: define ALU_SEQ_BACK2BACK_EN to let RESP hand off and accept
// the next command in the same cycle (RESP -> ISSUE).
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned A_WIDTH   = A_WIDTH_DEF,
    parameter int unsigned B_WIDTH   = B_WIDTH_DEF,
    parameter int unsigned OUT_WIDTH = OUT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [FUN_W-1:0]     cmd_fun,
    input  logic [A_WIDTH-1:0]   cmd_a,
    input  logic [B_WIDTH-1:0]   cmd_b,
    output logic [A_WIDTH-1:0]   A,
    output logic [B_WIDTH-1:0]   B,
    output logic [FUN_W-1:0]     ALU_FUN,
    output logic                 ARITH_Enable,
    output logic                 LOGIC_Enable,
    output logic                 CMP_Enable,
    output logic                 SHIFT_Enable,
    input  logic [OUT_WIDTH-1:0] ARITH_OUT,
    input  logic [OUT_WIDTH-1:0] LOGIC_OUT,
    input  logic [OUT_WIDTH-1:0] CMP_OUT,
    input  logic [OUT_WIDTH-1:0] SHIFT_OUT,
    input  logic                 ARITH_Flag,
    input  logic                 LOGIC_Flag,
    input  logic                 CMP_Flag,
    input  logic                 SHIFT_Flag,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [OUT_WIDTH-1:0] rsp_data,
    output logic [UNIT_W-1:0]    rsp_unit,
    output logic                 rsp_flag
);

    seq_state_t            state;
    unit_en_t              dec_en_c;
    unit_en_t              en_q;
    logic                  accept_c;
    logic [OUT_WIDTH-1:0]  sel_out_c;
    logic                  sel_flag_c;

    // Ready is gated by rst so it reads 0 throughout reset and 1 in the
    // very first cycle after release.
`ifdef ALU_SEQ_BACK2BACK_EN
    assign cmd_ready = rst & ((state == ST_IDLE) | ((state == ST_RESP) & rsp_ready));
`else
    assign cmd_ready = rst & (state == ST_IDLE);
`endif

    assign accept_c = cmd_valid & cmd_ready;

    // Enables are decoded from the incoming command and registered on accept,
    // so they are high exactly during ISSUE.
    alu_fun_decode u_decode (
        .unit_sel (cmd_fun[FUN_W-1 -: UNIT_W]),
        .issue    (accept_c),
        .en_c     (dec_en_c)
    );

    assign ARITH_Enable = en_q.arith_en;
    assign LOGIC_Enable = en_q.logic_en;
    assign CMP_Enable   = en_q.cmp_en;
    assign SHIFT_Enable = en_q.shift_en;

    // Result/flag select for the unit that was issued
    always_comb begin
        sel_out_c  = ARITH_OUT;
        sel_flag_c = ARITH_Flag;
        case (ALU_FUN[FUN_W-1 -: UNIT_W])
            UNIT_ARITH: begin sel_out_c = ARITH_OUT; sel_flag_c = ARITH_Flag; end
            UNIT_LOGIC: begin sel_out_c = LOGIC_OUT; sel_flag_c = LOGIC_Flag; end
            UNIT_CMP:   begin sel_out_c = CMP_OUT;   sel_flag_c = CMP_Flag;   end
            UNIT_SHIFT: begin sel_out_c = SHIFT_OUT; sel_flag_c = SHIFT_Flag; end
            default:    begin sel_out_c = ARITH_OUT; sel_flag_c = ARITH_Flag; end
        endcase
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            A         <= '0;
            B         <= '0;
            ALU_FUN   <= '0;
            en_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_unit  <= '0;
            rsp_flag  <= 1'b0;
        end else begin
            en_q <= dec_en_c;
            case (state)
                ST_IDLE: begin
                    if (accept_c) begin
                        A       <= cmd_a;
                        B       <= cmd_b;
                        ALU_FUN <= cmd_fun;
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    // Unit output registered at the end of ISSUE is valid now
                    rsp_data  <= sel_out_c;
                    rsp_flag  <= sel_flag_c;
                    rsp_unit  <= ALU_FUN[FUN_W-1 -: UNIT_W];
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
`ifdef ALU_SEQ_BACK2BACK_EN
                        if (accept_c) begin
                            A       <= cmd_a;
                            B       <= cmd_b;
                            ALU_FUN <= cmd_fun;
                            state   <= ST_ISSUE;
                        end
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 SHALL have parameter A_WIDTH, default 16, operand A width.
REQ-002 SHALL have parameter B_WIDTH, default 16, operand B width.
REQ-003 SHALL have parameter OUT_WIDTH, default 16, result width.
REQ-004 clk  in  1  clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at rising clk.
REQ-008 cmd_fun  in  4  ALU function code; [3:2] unit select, [1:0] sub-op.
REQ-009 cmd_a / cmd_b  in  A_WIDTH / B_WIDTH  operands.
REQ-010 A / B  out  A_WIDTH / B_WIDTH  registered operands driven to all units.
REQ-011 ALU_FUN  out  4  registered function code driven to all units.
REQ-012 ARITH_Enable, LOGIC_Enable, CMP_Enable, SHIFT_Enable  out  1 each  unit enables.
REQ-013 ARITH_OUT, LOGIC_OUT, CMP_OUT, SHIFT_OUT  in  OUT_WIDTH each  registered unit results.
REQ-014 ARITH_Flag, LOGIC_Flag, CMP_Flag, SHIFT_Flag  in  1 each  unit result flags.
REQ-015 rsp_valid  out  1  response present.
REQ-016 rsp_ready  in  1  response consumed when rsp_valid && rsp_ready at rising clk.
REQ-017 rsp_data  out  OUT_WIDTH  captured result.
REQ-018 rsp_unit  out  2  unit that produced rsp_data (= cmd_fun[3:2]).
REQ-019 rsp_flag  out  1  captured flag of that unit.

Function
REQ-020 Unit select SHALL be 00 arith, 01 logic, 10 cmp, 11 shift; all 16 cmd_fun codes legal.
REQ-021 FSM states SHALL be IDLE, ISSUE, CAPTURE, RESP.
REQ-022 IDLE: cmd_ready=1; on accept, register cmd_a, cmd_b, cmd_fun into A, B, ALU_FUN -> ISSUE; otherwise stay.
REQ-023 ISSUE: exactly one enable, selected by ALU_FUN[3:2], high for exactly this one cycle -> CAPTURE.
REQ-024 CAPTURE: all enables low; at the edge ending CAPTURE, register selected *_OUT into rsp_data, selected *_Flag into rsp_flag, ALU_FUN[3:2] into rsp_unit -> RESP.
REQ-025 RESP: rsp_valid=1; rsp_data, rsp_unit, rsp_flag held stable until rsp_ready=1, then -> IDLE.
REQ-026 Latency: rsp_valid SHALL rise exactly 3 clock edges after the accepting edge (ISSUE, CAPTURE, RESP).
REQ-027 cmd_ready SHALL be 0 in ISSUE, CAPTURE, and RESP (except per REQ-033); cmd_valid there is ignored.
REQ-028 Enables SHALL never be more than one-hot; outside ISSUE all SHALL be 0.
REQ-029 A, B, ALU_FUN SHALL hold their values from acceptance until the next acceptance.
REQ-030 rsp_valid low in IDLE, ISSUE, CAPTURE; rsp_data retains its last value when rsp_valid is low.

Reset
REQ-031 rst low SHALL asynchronously force IDLE and all outputs to 0 (cmd_ready=0 while in reset), regardless of state; an in-flight command is dropped without a response.
REQ-032 After rst deasserts, cmd_ready SHALL be 1 in the first cycle.

Configuration
REQ-033 Macro ALU_SEQ_BACK2BACK_EN defined: in RESP, cmd_ready = rsp_ready; a simultaneous response handoff and command accept SHALL go RESP -> ISSUE directly (one op per 3 cycles). Undefined: RESP always returns to IDLE (one op per 4 cycles); cmd_ready has no combinational path from rsp_ready.

Structure
REQ-034 Package alu_pkg SHALL hold the unit-select encoding constants, FSM state type, and default width constants.
REQ-035 Sub-module alu_fun_decode SHALL map the 2-bit unit select plus an issue strobe to the four one-hot enables (combinational).

Verification
REQ-036 Shift: cmd_fun=4'b1101, cmd_a=16'h4001 with SHIFT unit attached -> SHIFT_Enable high 1 cycle; rsp_data=16'h8002, rsp_unit=2'b11, rsp_flag=1; rsp_valid 3 edges after accept.
REQ-037 Enable check: cmd_fun=4'b0000, 4'b0100, 4'b1000 in turn -> only ARITH_Enable, then only LOGIC_Enable, then only CMP_Enable, each for exactly one cycle.
REQ-038 Stall: rsp_ready=0 for 5 cycles with cmd_valid=1 -> rsp_data stable, cmd_ready=0 throughout, no enable pulse; accept occurs one cycle after rsp_ready=1.
REQ-039 Reset mid-op: assert rst during ISSUE -> all outputs 0 immediately; after release cmd_ready=1, no rsp_valid for dropped command.
REQ-040 Throughput: 4 back-to-back commands with rsp_ready=1 -> 16 cycles without ALU_SEQ_BACK2BACK_EN, 12 cycles with it; results in order.
